pipe_if_fetch: RTL and testbench
================================

# pipe_if_fetch

Instruction-fetch stage of the pipelined CPU: owns the PC, runs a request/ready handshake to instruction memory, and feeds `pc_plus_4`/`inst` into the IF/ID pipeline register. It honours the ID-stage stall `wpcir` and an ID-stage `redirect`, which flushes the fetch. It always presents a NOP (`inst = 0`) when it has no valid instruction, so IF/ID captures a bubble.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset. Bits [1:0] must be 0.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `wpcir`  in  1: 1 = IF/ID captures this cycle (advance); 0 = stall.
- `redirect`  in  1: 1 = flush the fetch and load the PC from `redirect_pc`.
- `redirect_pc`  in  32: redirect target. Bits [1:0] are ignored and treated as 0.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch word address (byte address, 4-aligned).
- `imem_ready`  in  1: memory has data this cycle. Ignored while `imem_req` = 0.
- `imem_rdata`  in  32: instruction word, valid when `imem_ready` = 1.
- `pc`  out  32: address of the instruction currently offered.
- `pc_plus_4`  out  32: `pc` + 4, to IF/ID.
- `inst`  out  32: instruction to IF/ID. Equals 0 whenever `inst_valid` = 0.
- `inst_valid`  out  1: the offered instruction is real; 0 means a bubble.

## Operation
- States:
  - FETCH: request outstanding for `pc`.
  - HOLD: instruction buffered, waiting for `wpcir`.
  - DRAIN: a discarded request is still in flight.
- Registers:
  - `pc_r`
  - `drain_addr`
  - `inst_buf`
  - state
- `imem_addr` = `drain_addr` in DRAIN, `pc_r` otherwise.
- `imem_req` = 1 in FETCH and DRAIN, 0 in HOLD.
- Memory rule: once `imem_req` is high, `imem_req` and `imem_addr` stay stable until the cycle `imem_ready` = 1.
- FETCH, `imem_ready` = 1, `wpcir` = 1 (bypass):
  - `inst` = `imem_rdata`, `inst_valid` = 1.
  - Next: `pc_r` ← `pc_r` + 4, stay in FETCH.
- FETCH, `imem_ready` = 1, `wpcir` = 0:
  - `inst_valid` = 1, `inst` = `imem_rdata`.
  - Next: `inst_buf` ← `imem_rdata`, go to HOLD.
- FETCH, `imem_ready` = 0: `inst_valid` = 0, stay in FETCH.
- HOLD:
  - `inst` = `inst_buf`, `inst_valid` = 1.
  - If `wpcir` = 1: `pc_r` ← `pc_r` + 4, go to FETCH.
  - Otherwise stay in HOLD.
- DRAIN:
  - `inst_valid` = 0.
  - On `imem_ready` = 1, the data is discarded and the state goes to FETCH.
- `redirect` = 1 has priority over everything else in every state:
  - `inst_valid` = 0 that cycle, so any delivery is suppressed.
  - `pc_r` ← {`redirect_pc`[31:2], 2'b00}.
  - FETCH with `imem_ready` = 0: `drain_addr` ← `pc_r`, go to DRAIN.
  - FETCH with `imem_ready` = 1: data discarded, stay in FETCH.
  - HOLD: buffer dropped, go to FETCH.
  - DRAIN with `imem_ready` = 0: stay in DRAIN.
  - DRAIN with `imem_ready` = 1: go to FETCH.
- No branch-delay-slot handling here. The ID stage asserts `redirect` only for instructions that must be squashed.
- Arithmetic: `pc_r` + 4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset (asynchronous, any time, including with a request in flight):
  - `pc_r` = `RESET_PC`, state = FETCH, `inst_buf` = 0, `drain_addr` = 0.
  - Outputs: `inst` = 0, `inst_valid` = 0, `pc` = `RESET_PC`, `pc_plus_4` = `RESET_PC` + 4, `imem_req` = 1, `imem_addr` = `RESET_PC`.
  - A memory response arriving after reset release belongs to `RESET_PC` by construction; the memory is reset by the same `reset`.
- Latency with a zero-wait memory (`imem_ready` tied 1) and `wpcir` = 1: one instruction per cycle, combinational path `imem_rdata` → `inst`.
- An N-wait-state memory gives N bubbles per instruction.
- Stall during HOLD is unbounded. Outputs stay constant and no memory traffic occurs.
- Redirect penalty:
  - Next-cycle request to the target when no request is outstanding or `imem_ready` coincides with the redirect.
  - Otherwise the remaining wait of the old request, plus one cycle.

## Structure
- Shared package `pipe_pkg`:
  - state enum `if_state_t` (FETCH, HOLD, DRAIN).
  - `NOP_INST` = 32'h0.
  - `PC_STEP` = 4.
  - default `RESET_PC`.
- Single module. No sub-module is warranted: the next-PC mux and FSM share the same priority logic.

## Test plan
- Reset with `RESET_PC` = 32'h0000_0100, `imem_ready` = 1, `wpcir` = 1 → `imem_addr` sequence 0x100, 0x104, 0x108. `inst` equals the memory words with `inst_valid` = 1 every cycle; `pc_plus_4` = 0x104, 0x108, 0x10C.
- 3-wait-state memory → `inst_valid` pattern 0,0,0,1 repeating. `imem_addr` is held stable for all 4 cycles of each request.
- Data returns with `wpcir` = 0 held for 5 cycles → HOLD. `inst` is constant, `imem_req` = 0, PC unchanged. The first `wpcir` = 1 gives PC +4 and a new request.
- Redirect to 0x2000 while a 3-wait request for 0x40 is outstanding:
  - `imem_addr` stays 0x40 until ready, and that data is discarded with `inst_valid` = 0.
  - The next request is to 0x2000.
- Redirect in the same cycle as `imem_ready` = 1 with `redirect_pc` = 0x3003 → `inst_valid` = 0 that cycle, next `imem_addr` = 0x3000.
- PC = 0xFFFF_FFFC advancing → `pc_plus_4` = 0, next `imem_addr` = 0. Then assert `reset` mid-request → all outputs return to reset values immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and
// fetch constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pipe_if_fetch_if.sv
// Instruction-memory request/ready bus between the fetch stage (master)
// and instruction memory (slave).
interface pipe_if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pipe_if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake and offers
// pc_plus_4/inst to IF/ID, with stall (wpcir) and redirect/flush support.
module pipe_if_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wpcir,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  pipe_if_fetch_if.master         imem,
  output logic [31:0]             pc,
  output logic [31:0]             pc_plus_4,
  output logic [31:0]             inst,
  output logic                    inst_valid
);

  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] redirect_tgt;
  logic [1:0]  unused_rpc_lo;

  assign redirect_tgt  = {redirect_pc[31:2], 2'b00};
  assign unused_rpc_lo = redirect_pc[1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      inst_buf_q   <= NOP_INST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      inst_buf_q   <= inst_buf_d;
    end
  end

  // Redirect outranks stall and delivery; an unanswered request must be
  // drained so the memory handshake stays stable until its ready.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    inst_buf_d   = inst_buf_q;
    if (redirect) begin
      pc_d = redirect_tgt;
      unique case (state_q)
        FETCH: begin
          if (!imem.imem_ready) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end
        HOLD:    state_d = FETCH;
        DRAIN:   if (imem.imem_ready) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem.imem_ready) begin
            if (wpcir) begin
              pc_d = pc_q + PC_STEP;
            end else begin
              inst_buf_d = imem.imem_rdata;
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (wpcir) begin
            pc_d    = pc_q + PC_STEP;
            state_d = FETCH;
          end
        end
        DRAIN:   if (imem.imem_ready) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    imem.imem_req  = (state_q != HOLD);
    imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    pc             = pc_q;
    pc_plus_4      = pc_q + PC_STEP;
    inst_valid     = 1'b0;
    inst           = NOP_INST;
    unique case (state_q)
      FETCH: begin
        inst_valid = imem.imem_ready && !redirect;
        if (inst_valid) inst = imem.imem_rdata;
      end
      HOLD: begin
        inst_valid = !redirect;
        if (inst_valid) inst = inst_buf_q;
      end
      default: begin
        inst_valid = 1'b0;
        inst       = NOP_INST;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_if_fetch.sv
// Self-checking bench for pipe_if_fetch: wait-state memory model plus a
// transaction-level model of the expected instruction stream.
module tb_pipe_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clock;
  logic        reset;
  logic        wpcir;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc, pc_plus_4, inst;
  logic        inst_valid;

  pipe_if_fetch_if bus ();

  pipe_if_fetch #(.RESET_PC(RST_PC)) dut (
    .clock       (clock),
    .reset       (reset),
    .wpcir       (wpcir),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .pc          (pc),
    .pc_plus_4   (pc_plus_4),
    .inst        (inst),
    .inst_valid  (inst_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // memory model state
  int          waits;
  int          wait_cnt;
  // stream model state
  logic [31:0] exp_pc;
  bit          hold_pending;
  bit          drain_pending;
  bit          prev_outstanding;
  logic [31:0] prev_addr;
  // last observed values, for directed checks
  logic        last_valid;
  logic [31:0] last_addr;
  logic [31:0] last_inst;
  logic        last_req;
  logic [31:0] last_pc;
  logic [31:0] last_pc4;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc           = RST_PC;
    hold_pending     = 0;
    drain_pending    = 0;
    prev_outstanding = 0;
    prev_addr        = 32'h0;
    wait_cnt         = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_inst",  inst, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_pc",    pc, RST_PC);
    chk("rst_pc4",   pc_plus_4, RST_PC + 32'd4);
    chk("rst_req",   {31'h0, bus.imem_req}, 32'h1);
    chk("rst_addr",  bus.imem_addr, RST_PC);
  endtask

  // One cycle, entered and left at posedge+1.
  task automatic step(input logic w, input logic r, input logic [31:0] rpc);
    logic exp_valid;
    logic req_now, rdy_now;
    wpcir       = w;
    redirect    = r;
    redirect_pc = rpc;
    if (bus.imem_req && wait_cnt >= waits) begin
      bus.imem_ready = 1'b1;
      bus.imem_rdata = word(bus.imem_addr);
    end else begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
    end
    #1;
    req_now   = bus.imem_req;
    rdy_now   = bus.imem_ready;
    exp_valid = !r && (hold_pending || (rdy_now && !drain_pending));

    chk("pc", pc, exp_pc);
    chk("pc_plus_4", pc_plus_4, exp_pc + 32'd4);
    chk("inst_valid", {31'h0, inst_valid}, {31'h0, exp_valid});
    if (exp_valid) chk("inst", inst, word(exp_pc));
    else           chk("bubble_inst", inst, 32'h0);
    if (hold_pending) chk("hold_no_req", {31'h0, req_now}, 32'h0);
    if (prev_outstanding) begin
      chk("req_stable", {31'h0, req_now}, 32'h1);
      chk("addr_stable", bus.imem_addr, prev_addr);
    end else if (req_now) begin
      chk("fresh_addr", bus.imem_addr, exp_pc);
    end

    last_valid = inst_valid;
    last_addr  = bus.imem_addr;
    last_inst  = inst;
    last_req   = req_now;
    last_pc    = pc;
    last_pc4   = pc_plus_4;
    prev_outstanding = req_now && !rdy_now;
    prev_addr        = bus.imem_addr;

    @(posedge clock);
    if (req_now && rdy_now) wait_cnt = 0;
    else if (req_now)       wait_cnt++;
    if (r) begin
      exp_pc        = {rpc[31:2], 2'b00};
      hold_pending  = 0;
      drain_pending = req_now && !rdy_now;
    end else begin
      if (exp_valid && w)  begin exp_pc = exp_pc + 32'd4; hold_pending = 0; end
      else if (exp_valid)  hold_pending = 1;
      if (rdy_now) drain_pending = 0;
    end
    #1;
  endtask

  initial begin
    logic [31:0] held;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    wpcir       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    waits       = 0;
    model_reset();
    reset = 1'b1;
    #2;
    check_reset_outputs();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // zero-wait streaming
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("zw_addr", last_addr, RST_PC + 32'(4 * i));
      chk("zw_pc4",  last_pc4,  RST_PC + 32'(4 * (i + 1)));
      chk("zw_valid", {31'h0, last_valid}, 32'h1);
    end

    // 3-wait-state memory
    waits = 3;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("ws3_valid", {31'h0, last_valid}, {31'h0, (i % 4) == 3});
    end

    // stall while holding
    waits = 0;
    step(1'b0, 1'b0, 32'h0);
    held = last_inst;
    chk("hold_first_valid", {31'h0, last_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("hold_inst", last_inst, held);
      chk("hold_req",  {31'h0, last_req}, 32'h0);
      chk("hold_pc",   last_pc, RST_PC + 32'd20);
    end
    step(1'b1, 1'b0, 32'h0);
    chk("hold_release_inst", last_inst, held);
    step(1'b1, 1'b0, 32'h0);
    chk("hold_next_addr", last_addr, RST_PC + 32'd24);

    // redirect while a 3-wait request is outstanding
    waits = 3;
    step(1'b1, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("rd_req40", last_addr, 32'h40);
    step(1'b1, 1'b1, 32'h0000_2000);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("rd_drain_addr",  last_addr, 32'h40);
      chk("rd_drain_valid", {31'h0, last_valid}, 32'h0);
    end
    step(1'b1, 1'b0, 32'h0);
    chk("rd_target_addr", last_addr, 32'h2000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

    // redirect coinciding with ready
    waits = 0;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_3003);
    chk("rdy_rd_valid", {31'h0, last_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("rdy_rd_addr",  last_addr, 32'h3000);
    chk("rdy_rd_valid2", {31'h0, last_valid}, 32'h1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) waits = $urandom_range(0, 3);
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom);
    end

    // PC wraparound, then asynchronous reset mid-request
    waits = 0;
    step(1'b1, 1'b1, 32'hFFFF_FFFE);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_pc",  last_pc,  32'hFFFF_FFFC);
    chk("wrap_pc4", last_pc4, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_addr", last_addr, 32'h0);
    waits = 3;
    step(1'b1, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    chk("post_rst_pc", last_pc, RST_PC + 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
